// File: rtl/qam_tx_pkg.sv
// Shared definitions for the 16-QAM transmit path: state encoding, symbol width
// and default preamble/guard symbols used by the scheduler, modulator and source.
package qam_tx_pkg;

    localparam int SYM_W = 4;

    localparam logic [SYM_W-1:0] DEF_PRE_SYM_A = 4'hF;
    localparam logic [SYM_W-1:0] DEF_PRE_SYM_B = 4'h0;
    localparam logic [SYM_W-1:0] DEF_GUARD_SYM = 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        PAY   = 2'd2,
        GUARD = 2'd3
    } state_t;

endpackage

// File: rtl/qam_burst_ctrl_if.sv
// Control, payload-source and modulator-side signals of the burst scheduler.
// The master drives the request/source side; the slave is the scheduler.
interface qam_burst_ctrl_if;
    import qam_tx_pkg::*;

    logic             start;
    logic             abort;
    logic [7:0]       payload_len;
    logic [SYM_W-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic [SYM_W-1:0] sym_out;
    logic             sym_stb;
    logic             tx_en;
    logic             busy;
    logic             underrun;

    modport master (
        output start, abort, payload_len, data_in, data_valid,
        input  data_ready, sym_out, sym_stb, tx_en, busy, underrun
    );

    modport slave (
        input  start, abort, payload_len, data_in, data_valid,
        output data_ready, sym_out, sym_stb, tx_en, busy, underrun
    );

endinterface

// File: rtl/qam_sym_timer.sv
// Symbol-period prescaler: counts 0..SYM_DIV-1 while enabled, held at 0 otherwise.
// first/last mark the opening and closing clock of each symbol period.
module qam_sym_timer #(
    parameter int SYM_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic first,
    output logic last
);

    localparam int TW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [TW-1:0] LAST_CNT = TW'(SYM_DIV - 1);

    logic [TW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!en || cnt_reg == LAST_CNT) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + TW'(1);
        end
    end

    assign first = en && (cnt_reg == '0);
    assign last  = en && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/qam_burst_ctrl.sv
// Burst scheduler: preamble, payload and guard sequencing at a fixed symbol rate,
// with a one-cycle-per-symbol pull from the payload source.
module qam_burst_ctrl
    import qam_tx_pkg::*;
#(
    parameter int               SYM_DIV   = 8,
    parameter int               PRE_LEN   = 16,
    parameter int               GUARD_LEN = 4,
    parameter logic [SYM_W-1:0] PRE_SYM_A = DEF_PRE_SYM_A,
    parameter logic [SYM_W-1:0] PRE_SYM_B = DEF_PRE_SYM_B,
    parameter logic [SYM_W-1:0] GUARD_SYM = DEF_GUARD_SYM
) (
    input  logic              clock_5000,
    input  logic              reset,
    qam_burst_ctrl_if.slave   bus
);

    state_t           state_reg, state_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic [7:0]       len_reg, len_next;
    logic [SYM_W-1:0] sym_reg, sym_next;
    logic             abort_pend_reg, abort_pend_next;
    logic             underrun_reg, underrun_next;

    logic active;
    logic sym_first;
    logic sym_last;
    logic ready;
    logic abort_hit;

    assign active = (state_reg != IDLE);

    qam_sym_timer #(.SYM_DIV(SYM_DIV)) u_timer (
        .clk   (clock_5000),
        .rst_n (reset),
        .en    (active),
        .first (sym_first),
        .last  (sym_last)
    );

    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            len_reg        <= '0;
            sym_reg        <= '0;
            abort_pend_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            len_reg        <= len_next;
            sym_reg        <= sym_next;
            abort_pend_reg <= abort_pend_next;
            underrun_reg   <= underrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        len_next        = len_reg;
        sym_next        = sym_reg;
        abort_pend_next = abort_pend_reg;
        underrun_next   = underrun_reg;
        ready           = 1'b0;
        // An abort arriving in the closing cycle still takes effect at this boundary.
        abort_hit       = abort_pend_reg || bus.abort;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next      = PRE;
                    cnt_next        = '0;
                    len_next        = bus.payload_len;
                    sym_next        = PRE_SYM_A;
                    abort_pend_next = 1'b0;
                    underrun_next   = 1'b0;
                end
            end
            PRE: begin
                if (sym_last) begin
                    if (cnt_reg == 8'(PRE_LEN - 1)) begin
                        cnt_next = '0;
                        if (len_reg == 8'd0) begin
                            state_next = GUARD;
                            sym_next   = GUARD_SYM;
                        end else begin
                            state_next = PAY;
                            ready      = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                        // cnt_reg odd means the upcoming symbol index is even.
                        sym_next = cnt_reg[0] ? PRE_SYM_A : PRE_SYM_B;
                    end
                end
            end
            PAY: begin
                abort_pend_next = abort_pend_reg || bus.abort;
                if (sym_last) begin
                    abort_pend_next = 1'b0;
                    if (abort_hit || cnt_reg == len_reg - 8'd1) begin
                        state_next = GUARD;
                        cnt_next   = '0;
                        sym_next   = GUARD_SYM;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                        ready    = 1'b1;
                    end
                end
            end
            GUARD: begin
                if (sym_last) begin
                    if (cnt_reg == 8'(GUARD_LEN - 1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        sym_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                        sym_next = GUARD_SYM;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A pulled slot always counts; a missing symbol is replaced by GUARD_SYM.
        if (ready) begin
            if (bus.data_valid) begin
                sym_next = bus.data_in;
            end else begin
                sym_next      = GUARD_SYM;
                underrun_next = 1'b1;
            end
        end
    end

    assign bus.data_ready = ready;
    assign bus.sym_out    = sym_reg;
    assign bus.sym_stb    = sym_first;
    assign bus.tx_en      = active;
    assign bus.busy       = active;
    assign bus.underrun   = underrun_reg;

endmodule

// File: tb/tb_qam_burst_ctrl.sv
// Directed bench for qam_burst_ctrl at default parameters: burst shapes, len=0,
// underrun, abort, ignored starts, back-to-back start and asynchronous reset.
module tb_qam_burst_ctrl;

    logic clock_5000 = 1'b0;
    logic reset      = 1'b0;

    qam_burst_ctrl_if bus ();

    qam_burst_ctrl dut (
        .clock_5000 (clock_5000),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clock_5000 = ~clock_5000;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  pay_data [16];
    logic [15:0] vmask = 16'hFFFF;
    logic [3:0]  rdy_seen = 4'd0;

    // Source model: one table entry per data_ready pulse of the current burst.
    assign bus.data_in    = pay_data[rdy_seen];
    assign bus.data_valid = vmask[rdy_seen];

    always @(posedge clock_5000) begin
        if (!reset)
            rdy_seen <= 4'd0;
        else if (bus.start && !bus.busy)
            rdy_seen <= 4'd0;
        else if (bus.data_ready)
            rdy_seen <= rdy_seen + 4'd1;
    end

    int cyc      = 0;
    int busy_cnt = 0;
    int rdy_cnt  = 0;
    logic [3:0] stb_syms [$];
    int         stb_cyc  [$];

    always @(posedge clock_5000) cyc <= cyc + 1;

    always @(negedge clock_5000) begin
        if (bus.busy)       busy_cnt <= busy_cnt + 1;
        if (bus.data_ready) rdy_cnt  <= rdy_cnt + 1;
        if (bus.sym_stb) begin
            stb_syms.push_back(bus.sym_out);
            stb_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clock_5000);
        #1;
    endtask

    task automatic launch(input logic [7:0] len);
        bus.payload_len = len;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            tick();
            n++;
        end
        if (bus.busy) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_stb(input string tag, input int target, input int limit);
        int n = 0;
        while (stb_syms.size() < target && n < limit) begin
            tick();
            n++;
        end
        if (stb_syms.size() < target) check_eq({tag, "_stb_timeout"}, 32'd1, 32'd0);
    endtask

    // Compares the symbol stream of one burst: 16 alternating preamble symbols,
    // the expected payload, then 4 guard symbols, each 8 clocks apart.
    task automatic check_burst(input string tag, input int s0, input int n_pay,
                               input logic [3:0] exp_pay [16]);
        int n_exp = 16 + n_pay + 4;
        logic [3:0] e;
        check_eq({tag, "_nsym"}, 32'(stb_syms.size() - s0), 32'(n_exp));
        for (int i = 0; i < n_exp && s0 + i < stb_syms.size(); i++) begin
            if (i < 16)              e = (i % 2 == 0) ? 4'hF : 4'h0;
            else if (i < 16 + n_pay) e = exp_pay[i - 16];
            else                     e = 4'h0;
            check_eq($sformatf("%s_sym%0d", tag, i), 32'(stb_syms[s0 + i]), 32'(e));
            if (i > 0)
                check_eq($sformatf("%s_gap%0d", tag, i),
                         32'(stb_cyc[s0 + i] - stb_cyc[s0 + i - 1]), 32'd8);
        end
    endtask

    initial begin
        logic [3:0] ep [16];
        int s0, b0, r0;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.payload_len = 8'd0;
        for (int i = 0; i < 16; i++) pay_data[i] = 4'(i + 1);
        for (int i = 0; i < 16; i++) ep[i] = 4'h0;

        repeat (3) tick();
        check_eq("rst_busy",     32'(bus.busy), 32'd0);
        check_eq("rst_tx_en",    32'(bus.tx_en), 32'd0);
        check_eq("rst_sym_out",  32'(bus.sym_out), 32'd0);
        check_eq("rst_sym_stb",  32'(bus.sym_stb), 32'd0);
        check_eq("rst_ready",    32'(bus.data_ready), 32'd0);
        check_eq("rst_underrun", 32'(bus.underrun), 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Basic burst len=3, data 1,2,3.
        s0 = stb_syms.size(); b0 = busy_cnt; r0 = rdy_cnt;
        launch(8'd3);
        check_eq("t1_first_busy", 32'(bus.busy), 32'd1);
        check_eq("t1_first_stb",  32'(bus.sym_stb), 32'd1);
        check_eq("t1_first_sym",  32'(bus.sym_out), 32'hF);
        wait_idle("t1", 400);
        ep[0] = 4'h1; ep[1] = 4'h2; ep[2] = 4'h3;
        check_burst("t1", s0, 3, ep);
        check_eq("t1_busy_cycles", 32'(busy_cnt - b0), 32'd184);
        check_eq("t1_ready_cnt",   32'(rdy_cnt - r0), 32'd3);
        check_eq("t1_underrun",    32'(bus.underrun), 32'd0);
        check_eq("t1_end_sym",     32'(bus.sym_out), 32'd0);
        check_eq("t1_end_tx_en",   32'(bus.tx_en), 32'd0);

        // len=0: preamble and guard only.
        s0 = stb_syms.size(); b0 = busy_cnt; r0 = rdy_cnt;
        launch(8'd0);
        wait_idle("t2", 400);
        check_burst("t2", s0, 0, ep);
        check_eq("t2_busy_cycles", 32'(busy_cnt - b0), 32'd160);
        check_eq("t2_ready_cnt",   32'(rdy_cnt - r0), 32'd0);

        // Underrun on the 2nd pull of a len=4 burst.
        pay_data[0] = 4'h5; pay_data[1] = 4'h6; pay_data[2] = 4'h7; pay_data[3] = 4'h8;
        vmask = 16'hFFFD;
        s0 = stb_syms.size();
        launch(8'd4);
        wait_idle("t3", 400);
        ep[0] = 4'h5; ep[1] = 4'h0; ep[2] = 4'h7; ep[3] = 4'h8;
        check_burst("t3", s0, 4, ep);
        check_eq("t3_underrun_end", 32'(bus.underrun), 32'd1);
        repeat (10) tick();
        check_eq("t3_underrun_sticky", 32'(bus.underrun), 32'd1);
        vmask = 16'hFFFF;
        for (int i = 0; i < 16; i++) pay_data[i] = 4'(i + 1);
        launch(8'd0);
        check_eq("t3_underrun_cleared", 32'(bus.underrun), 32'd0);
        wait_idle("t3b", 400);

        // Abort during payload symbol 2 of a len=10 burst.
        s0 = stb_syms.size(); b0 = busy_cnt; r0 = rdy_cnt;
        launch(8'd10);
        wait_stb("t4", s0 + 19, 400);
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        wait_idle("t4", 400);
        ep[0] = 4'h1; ep[1] = 4'h2; ep[2] = 4'h3;
        check_burst("t4", s0, 3, ep);
        check_eq("t4_ready_cnt",   32'(rdy_cnt - r0), 32'd3);
        check_eq("t4_busy_cycles", 32'(busy_cnt - b0), 32'd184);

        // Starts during PAY and GUARD are ignored; start right after busy falls works.
        s0 = stb_syms.size(); b0 = busy_cnt;
        launch(8'd2);
        wait_stb("t5", s0 + 17, 400);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_stb("t5", s0 + 19, 400);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_idle("t5", 400);
        check_burst("t5", s0, 2, ep);
        check_eq("t5_busy_cycles", 32'(busy_cnt - b0), 32'd176);
        launch(8'd0);
        check_eq("t5_b2b_busy", 32'(bus.busy), 32'd1);
        check_eq("t5_b2b_stb",  32'(bus.sym_stb), 32'd1);
        check_eq("t5_b2b_sym",  32'(bus.sym_out), 32'hF);
        wait_idle("t5b", 400);

        // Reset clears a sticky underrun while idle.
        vmask = 16'h0000;
        launch(8'd1);
        wait_idle("t6", 400);
        check_eq("t6_underrun_set", 32'(bus.underrun), 32'd1);
        #2 reset = 1'b0;
        #1 check_eq("t6_underrun_rst", 32'(bus.underrun), 32'd0);
        tick();
        reset = 1'b1;
        vmask = 16'hFFFF;
        tick();

        // Asynchronous reset around cycle 50 of a burst.
        launch(8'd3);
        repeat (48) tick();
        check_eq("t7_busy_before", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("t7_async_busy",  32'(bus.busy), 32'd0);
        check_eq("t7_async_tx_en", 32'(bus.tx_en), 32'd0);
        check_eq("t7_async_sym",   32'(bus.sym_out), 32'd0);
        check_eq("t7_async_stb",   32'(bus.sym_stb), 32'd0);
        tick();
        reset = 1'b1;
        s0 = stb_syms.size();
        repeat (20) tick();
        check_eq("t7_idle_busy",  32'(bus.busy), 32'd0);
        check_eq("t7_idle_tx_en", 32'(bus.tx_en), 32'd0);
        check_eq("t7_idle_stbs",  32'(stb_syms.size() - s0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
